bcd_seg_scanner: RTL and testbench

- Downstream display stage for the BCD up/down counters.
- Accepts NUM_DIGITS packed BCD digits and drives a time-multiplexed common-anode/cathode 7-segment display: one digit per scan slot, with segment decode, leading-zero blanking and tear-free frame-aligned updates.
- Sits between the counter bank and the board-level display pins.

---
 rtl/bcd_disp_pkg.sv | 24 ++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/bcd_seg_scanner.sv | 116 +++++++++++
 tb/tb_bcd_seg_scanner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD 7-segment display path.
// Segment codes are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic [7:0] digit_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  bcd_digit_t  i_digit,
  output logic [6:0]  o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 7-segment scanner with leading-zero blanking and
// frame-aligned display updates; polarity is applied only at the outputs.
module bcd_seg_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_bcd;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_disp_bcd;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tc;
  logic                    w_wrap;
  bcd_digit_t              w_digit;
  logic [6:0]              w_seg_dec;
  logic [NUM_DIGITS-1:0]   w_any_hi;
  logic                    w_blank;
  logic [6:0]              w_seg;
  logic                    w_dp;
  logic [7:0]              w_oh;
  logic [NUM_DIGITS-1:0]   w_an;

  assign w_tc   = (r_presc == PRESC_LAST);
  assign w_wrap = w_tc && (r_idx == IDX_LAST);

  assign w_digit = r_disp_bcd[4*r_idx +: 4];

  bcd_to_7seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg_dec)
  );

  // w_any_hi[k]: digit k or any more significant digit holds a non-zero code
  always_comb begin
    w_any_hi = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_any_hi[k] = |(r_disp_bcd >> (4*k));
    end
  end

  always_comb begin
    w_blank = blank_lz && (r_idx != '0) && !w_any_hi[r_idx];
    w_seg   = w_blank ? SEG_OFF : w_seg_dec;
    w_dp    = r_disp_dp[r_idx];
    w_oh    = digit_onehot(3'(r_idx));
    w_an    = w_oh[NUM_DIGITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pend_bcd   <= '0;
      r_pend_dp    <= '0;
      r_disp_bcd   <= '0;
      r_disp_dp    <= '0;
      r_frame_done <= 1'b0;
      r_seg        <= {7{SEG_INV}};
      r_dp         <= SEG_INV;
      r_an         <= {NUM_DIGITS{AN_INV}};
    end else begin
      r_presc <= w_tc ? '0 : r_presc + 1'b1;
      if (w_tc) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      if (load) begin
        r_pend_bcd <= bcd_in;
        r_pend_dp  <= dp_in;
      end
      // A load landing on the wrap cycle bypasses pending so no stale frame is shown
      if (w_wrap) begin
        r_disp_bcd <= load ? bcd_in : r_pend_bcd;
        r_disp_dp  <= load ? dp_in  : r_pend_dp;
      end
      r_frame_done <= w_wrap;
      r_seg        <= w_seg ^ {7{SEG_INV}};
      r_dp         <= w_dp ^ SEG_INV;
      r_an         <= w_an ^ {NUM_DIGITS{AN_INV}};
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed self-checking bench for bcd_seg_scanner (4 digits, SCAN_DIV=4, active-low).
module tb_bcd_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_pass  = 0;
  int n_total = 0;
  int n_edge  = 0;

  always #5 clk = ~clk;

  bcd_seg_scanner #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // Hand-written active-low segment patterns {g..a}
  function automatic logic [6:0] seg_lo(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Digit shown on the outputs after rising edge n following reset release
  function automatic int exp_dig(input int n);
    return ((n - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] an_lo(input int d);
    logic [3:0] t;
    t = 4'b0001 << d;
    return ~t;
  endfunction

  task automatic tick();
    @(posedge clk);
    n_edge++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
    repeat (3) tick();
    n_total++; if (an !== 4'b1111) $display("FAIL reset_an got=%b exp=%b", an, 4'b1111); else n_pass++;
    n_total++; if (seg !== 7'h7F) $display("FAIL reset_seg got=%b exp=%b", seg, 7'h7F); else n_pass++;
    n_total++; if (dp !== 1'b1) $display("FAIL reset_dp got=%b exp=1", dp); else n_pass++;
    n_total++; if (frame_done !== 1'b0) $display("FAIL reset_fd got=%b exp=0", frame_done); else n_pass++;
    reset = 1'b0;
    n_edge = 0;
    tick();
    n_total++; if (an !== 4'b1110) $display("FAIL first_an got=%b exp=1110", an); else n_pass++;
    n_total++; if (seg !== 7'b1000000) $display("FAIL first_seg got=%b exp=1000000", seg); else n_pass++;
  endtask

  task automatic test_scan();
    while (n_edge < 32) begin
      tick();
      n_total++;
      if (an !== an_lo(exp_dig(n_edge)))
        $display("FAIL scan_an n=%0d got=%b exp=%b", n_edge, an, an_lo(exp_dig(n_edge)));
      else n_pass++;
      n_total++;
      if (frame_done !== (n_edge % 16 == 0))
        $display("FAIL scan_fd n=%0d got=%b exp=%b", n_edge, frame_done, (n_edge % 16 == 0));
      else n_pass++;
      n_total++;
      if (seg !== 7'b1000000 || dp !== 1'b1)
        $display("FAIL scan_seg n=%0d got=%b/%b exp=1000000/1", n_edge, seg, dp);
      else n_pass++;
    end
  endtask

  task automatic test_load_midframe();
    logic [15:0] v;
    logic [6:0]  es;
    logic        ed;
    int          d;
    v = 16'h1234;
    while (n_edge < 38) tick();
    bcd_in = v; dp_in = 4'b0010; load = 1'b1;
    tick();
    load = 1'b0; bcd_in = '0; dp_in = '0;
    while (n_edge < 64) begin
      tick();
      d  = exp_dig(n_edge);
      es = (n_edge <= 48) ? 7'b1000000 : seg_lo(4'((v >> (4*d)) & 16'hF));
      ed = (n_edge <= 48) ? 1'b1 : (d != 1);
      n_total++;
      if (seg !== es || dp !== ed || an !== an_lo(d))
        $display("FAIL load_mid n=%0d got=%b/%b/%b exp=%b/%b/%b", n_edge, seg, dp, an, es, ed, an_lo(d));
      else n_pass++;
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] es;
    int         d;
    blank_lz = 1'b1;
    bcd_in = 16'h0070; load = 1'b1;
    tick();
    load = 1'b0; bcd_in = '0;
    while (n_edge < 96) begin
      tick();
      if (n_edge > 80) begin
        d  = exp_dig(n_edge);
        es = (d == 0) ? 7'b1000000 : (d == 1) ? 7'b1111000 : 7'b1111111;
        n_total++;
        if (seg !== es || an !== an_lo(d) || dp !== 1'b1)
          $display("FAIL blank n=%0d got=%b/%b/%b exp=%b/%b/1", n_edge, seg, an, dp, es, an_lo(d));
        else n_pass++;
      end
    end
  endtask

  task automatic test_dash();
    logic [6:0] es;
    int         d;
    bcd_in = 16'h00A5; load = 1'b1;
    tick();
    load = 1'b0; bcd_in = '0;
    while (n_edge < 128) begin
      tick();
      if (n_edge > 112) begin
        d  = exp_dig(n_edge);
        es = (d == 0) ? 7'b0010010 : (d == 1) ? 7'b0111111 : 7'b1111111;
        n_total++;
        if (seg !== es || an !== an_lo(d))
          $display("FAIL dash n=%0d got=%b/%b exp=%b/%b", n_edge, seg, an, es, an_lo(d));
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    while (n_edge < 143) tick();
    bcd_in = 16'h9999; load = 1'b1;
    tick();
    load = 1'b0; bcd_in = '0;
    n_total++; if (frame_done !== 1'b1) $display("FAIL wrap_fd got=%b exp=1", frame_done); else n_pass++;
    while (n_edge < 176) begin
      tick();
      n_total++;
      if (seg !== 7'b0010000 || an !== an_lo(exp_dig(n_edge)))
        $display("FAIL wrap_load n=%0d got=%b/%b exp=0010000/%b", n_edge, seg, an, an_lo(exp_dig(n_edge)));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] es;
    while (n_edge < 186) tick();
    n_total++; if (an !== 4'b1011) $display("FAIL pre_reset_an got=%b exp=1011", an); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0)
      $display("FAIL mid_reset got=%b/%b/%b/%b exp=1111/1111111/1/0", an, seg, dp, frame_done);
    else n_pass++;
    reset = 1'b0;
    n_edge = 0;
    tick();
    n_total++; if (an !== 4'b1110) $display("FAIL restart_an got=%b exp=1110", an); else n_pass++;
    while (n_edge < 32) begin
      tick();
      es = (exp_dig(n_edge) == 0) ? 7'b1000000 : 7'b1111111;
      n_total++;
      if (seg !== es || an !== an_lo(exp_dig(n_edge)))
        $display("FAIL pend_clear n=%0d got=%b/%b exp=%b/%b", n_edge, seg, an, es, an_lo(exp_dig(n_edge)));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_blank_lz();
    test_dash();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
